sram_readback_checker: RTL and testbench
========================================

Name: sram_readback_checker

Overview:
- Read-side companion to the pattern writer that fills the example_sram macro. Drives the same macro pins (CEN, GWEN, WEN, A, D, RETN, EMA, Q) in read-only mode.
- On `start`, sweeps every address, compares Q against the expected pattern `base + addr`, and reports pass/fail, mismatch count and the first failing location.
- Sits beside the writer on the SRAM pins; top-level muxes pin ownership. Result feeds the status LED / debug registers.

Parameters:
- ADDR_W, 12, SRAM address width; sweep depth = 2**ADDR_W.
- DATA_W, 32, SRAM word width.
- EMA_VAL, 3'b000, constant driven on EMA.

Ports:
- top_clk  in  1  sole clock; also drives the macro CLK at top level.
- top_reset_n  in  1  synchronous active-low reset.
- start  in  1  one-cycle pulse; begins a sweep from IDLE or DONE.
- base  in  DATA_W  pattern base; sampled on the accepted start.
- busy  out  1  high while sweeping.
- done  out  1  high from sweep completion until the next accepted start or reset.
- pass  out  1  valid when done; 1 iff err_count == 0.
- err_count  out  ADDR_W+1  number of mismatching words.
- first_err_addr  out  ADDR_W  address of the lowest-address mismatch.
- first_err_data  out  DATA_W  Q value read at first_err_addr.
- CEN  out  1  chip enable, active low.
- GWEN  out  1  global write enable, active low; held 1.
- WEN  out  4  byte write enables, active low; held 4'hF.
- A  out  ADDR_W  read address.
- D  out  DATA_W  held 0.
- RETN  out  1  = top_reset_n (combinational).
- EMA  out  3  = EMA_VAL.
- Q  in  DATA_W  macro read data; valid in the cycle after the edge that captured A.

Behaviour:
- Reset (top_reset_n=0 at a top_clk edge) forces the following; takes effect at any point, including mid-sweep:
  - state=IDLE, CEN=1, A=0.
  - busy=0, done=0, pass=0, err_count=0, first_err_addr=0, first_err_data=0.
  - Compare pipeline valid cleared.
- States:
  - IDLE: on start, latch base, clear results, addr=0, go to READ.
  - READ: CEN=0, A=addr. Increment addr each cycle. After driving addr = 2**ADDR_W-1, go to DRAIN.
  - DRAIN: CEN=1; wait for the final compare; go to DONE.
  - DONE: done=1, CEN=1. On start, behave as in IDLE.
- busy=1 in READ and DRAIN. start is ignored while busy.
- Timing, with E = the edge accepting start:
  - Address k is driven in the cycle after edge E+k.
  - The macro captures address k at edge E+k+1.
  - The compare for address k registers at edge E+k+2, using a one-stage delayed copy of addr and valid.
- done, pass and final counts update at edge E+N+1, with N = 2**ADDR_W (4097 edges for ADDR_W=12).
- Expected value for address k = (base + k) mod 2**DATA_W, zero-extended from ADDR_W.
- Mismatch handling:
  - On each mismatch, err_count increments.
  - On the first mismatch of the sweep only, capture first_err_addr and first_err_data.
  - err_count cannot overflow: max value is N, which fits in ADDR_W+1 bits.
- Outputs hold their last values while in DONE.
- GWEN=1 and WEN=4'hF in every state, including reset; the block never writes.

Optional Feature:
- SRAM_RD_STOP_ON_FAIL_EN defined:
  - On the first mismatch compare, abort the sweep: CEN=1 from the next cycle, go to DONE at the following edge.
  - Results: err_count=1, pass=0, first_err_* captured.
  - The in-flight read issued in the abort cycle is discarded, not compared.
- Undefined: always complete the full sweep and count every mismatch.

Test Plan:
- Preload mem[k]=k, base=0, pulse start → CEN low for exactly 4096 consecutive cycles with A=0..4095; done at edge start+4097; pass=1, err_count=0.
- Preload mem[k]=0xFFFF_FFFF+k (wrapping), base=0xFFFF_FFFF → mem[1]=0 is treated as a match; pass=1.
- Preload mem[k]=k except mem[0x123]=0xDEAD_BEEF and mem[0x800]=0 → err_count=2, first_err_addr=0x123, first_err_data=0xDEAD_BEEF, pass=0.
  - Same stimulus with SRAM_RD_STOP_ON_FAIL_EN → err_count=1, done within 3 cycles of A=0x123, and A never reaches 0x800.
- Drop top_reset_n while A=0x400 → at the next edge CEN=1, busy=0, done=0, err_count=0. A new start after reset performs a full clean sweep.
- Pulse start at A=0x010 during a sweep → no restart, A continues 0x011. Pulse start in DONE → results cleared, new sweep begins with A=0 at the next cycle.

Source files
------------

// File: rtl/sram_readback_checker_if.sv
// Pin bundle shared between the readback checker and the example_sram macro.
interface sram_readback_checker_if #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DATA_W = 32
);
  logic              CEN;
  logic              GWEN;
  logic [3:0]        WEN;
  logic [ADDR_W-1:0] A;
  logic [DATA_W-1:0] D;
  logic              RETN;
  logic [2:0]        EMA;
  logic [DATA_W-1:0] Q;

  modport master (output CEN, GWEN, WEN, A, D, RETN, EMA, input Q);
  modport slave  (input CEN, GWEN, WEN, A, D, RETN, EMA, output Q);
endinterface

// File: rtl/sram_readback_checker.sv
// Read-only sweep of the SRAM comparing every word against base + addr.
// Optional feature macro: SRAM_RD_STOP_ON_FAIL_EN (abort the sweep on the first mismatch).
module sram_readback_checker #(
  parameter int unsigned ADDR_W  = 12,
  parameter int unsigned DATA_W  = 32,
  parameter logic [2:0]  EMA_VAL = 3'b000
) (
  input  logic                top_clk,
  input  logic                top_reset_n,
  input  logic                start,
  input  logic [DATA_W-1:0]   base,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [ADDR_W:0]     err_count,
  output logic [ADDR_W-1:0]   first_err_addr,
  output logic [DATA_W-1:0]   first_err_data,
  sram_readback_checker_if.master sram
);

  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_DRAIN, ST_DONE} state_t;

  state_t            state;
  logic              cen;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] base_r;
  logic              rd_valid;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] expected_c;
  logic              mismatch_c;
  logic [CNT_W-1:0]  err_next_c;

  // The block never writes: write controls are tied off in every state.
  assign sram.CEN  = cen;
  assign sram.A    = addr;
  assign sram.GWEN = 1'b1;
  assign sram.WEN  = 4'hF;
  assign sram.D    = '0;
  assign sram.RETN = top_reset_n;
  assign sram.EMA  = EMA_VAL;

  always_comb begin
    expected_c = base_r + DATA_W'(rd_addr);
    mismatch_c = rd_valid && (sram.Q != expected_c);
    err_next_c = err_count + CNT_W'(mismatch_c);
  end

  always_ff @(posedge top_clk) begin
    if (!top_reset_n) begin
      state          <= ST_IDLE;
      cen            <= 1'b1;
      addr           <= '0;
      base_r         <= '0;
      rd_valid       <= 1'b0;
      rd_addr        <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      err_count      <= '0;
      first_err_addr <= '0;
      first_err_data <= '0;
    end else begin
      // One-stage delayed address/valid lines up with Q of the captured read.
      rd_valid <= (state == ST_READ);
      rd_addr  <= addr;

      if (mismatch_c) begin
        err_count <= err_next_c;
        if (err_count == '0) begin
          first_err_addr <= rd_addr;
          first_err_data <= sram.Q;
        end
      end

      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            base_r         <= base;
            err_count      <= '0;
            first_err_addr <= '0;
            first_err_data <= '0;
            done           <= 1'b0;
            pass           <= 1'b0;
            busy           <= 1'b1;
            cen            <= 1'b0;
            addr           <= '0;
            state          <= ST_READ;
          end
        end
        ST_READ: begin
`ifdef SRAM_RD_STOP_ON_FAIL_EN
          if (mismatch_c) begin
            cen      <= 1'b1;
            rd_valid <= 1'b0;
            state    <= ST_DRAIN;
          end else
`endif
          if (addr == LAST_ADDR) begin
            cen   <= 1'b1;
            state <= ST_DRAIN;
          end else begin
            addr <= addr + 1'b1;
          end
        end
        ST_DRAIN: begin
          // The last in-flight compare lands on this edge, so judge on err_next_c.
          state <= ST_DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
          pass  <= (err_next_c == '0);
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_readback_checker.sv
// Directed bench for sram_readback_checker with a behavioural SRAM read model.
module tb_sram_readback_checker;

  localparam int unsigned ADDR_W = 12;
  localparam int unsigned DATA_W = 32;
  localparam int          N      = 1 << ADDR_W;

  logic              top_clk = 1'b0;
  logic              top_reset_n;
  logic              start;
  logic [DATA_W-1:0] base;
  logic              busy;
  logic              done;
  logic              pass;
  logic [ADDR_W:0]   err_count;
  logic [ADDR_W-1:0] first_err_addr;
  logic [DATA_W-1:0] first_err_data;

  logic [DATA_W-1:0] mem [0:N-1];
  logic [DATA_W-1:0] q_r;

  int n_checks = 0;
  int n_fail   = 0;

  sram_readback_checker_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) sif ();

  sram_readback_checker #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .EMA_VAL(3'b000)) dut (
    .top_clk        (top_clk),
    .top_reset_n    (top_reset_n),
    .start          (start),
    .base           (base),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .err_count      (err_count),
    .first_err_addr (first_err_addr),
    .first_err_data (first_err_data),
    .sram           (sif)
  );

  always #5 top_clk = ~top_clk;

  // Macro read model: Q valid in the cycle after the edge that captured A.
  always @(posedge top_clk) if (!sif.CEN) q_r <= mem[sif.A];
  assign sif.Q = q_r;

  task automatic fill_clean();
    for (int k = 0; k < N; k++) mem[k] = 32'(k);
  endtask

  // Pulse start and watch the sweep; j counts negedges after the accepting edge.
  task automatic do_sweep(input logic [DATA_W-1:0] b, output int done_j, output int cen_low,
                          output int seq_bad, output int max_a, output logic busy0);
    @(negedge top_clk); base = b; start = 1'b1;
    @(negedge top_clk); start = 1'b0;
    done_j = -1; cen_low = 0; seq_bad = 0; max_a = 0; busy0 = busy;
    for (int j = 0; j < N + 20; j++) begin
      if (j > 0) @(negedge top_clk);
      if (!sif.CEN) begin
        if (int'(sif.A) != j) seq_bad++;
        cen_low++;
        if (int'(sif.A) > max_a) max_a = int'(sif.A);
      end
      if (done) begin done_j = j; break; end
    end
  endtask

  task automatic test_reset();
    top_reset_n = 1'b0; start = 1'b0; base = '0;
    repeat (3) @(negedge top_clk);
    n_checks++; if (sif.CEN !== 1'b1) begin n_fail++; $display("FAIL reset_cen: got %b expected 1", sif.CEN); end
    n_checks++; if (sif.A !== 12'h000) begin n_fail++; $display("FAIL reset_a: got %0h expected 0", sif.A); end
    n_checks++; if ({busy, done, pass} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %b expected 000", {busy, done, pass}); end
    n_checks++; if (err_count !== 13'd0 || first_err_addr !== 12'h0 || first_err_data !== 32'h0) begin
      n_fail++; $display("FAIL reset_results: got %0h/%0h/%0h expected 0/0/0", err_count, first_err_addr, first_err_data); end
    n_checks++; if ({sif.GWEN, sif.WEN} !== 5'h1F || sif.D !== 32'h0 || sif.EMA !== 3'b000) begin
      n_fail++; $display("FAIL reset_tieoffs: got gwen=%b wen=%h d=%0h ema=%b expected 1/f/0/000", sif.GWEN, sif.WEN, sif.D, sif.EMA); end
    n_checks++; if (sif.RETN !== 1'b0) begin n_fail++; $display("FAIL reset_retn_low: got %b expected 0", sif.RETN); end
    top_reset_n = 1'b1;
    @(negedge top_clk);
    n_checks++; if (sif.RETN !== 1'b1) begin n_fail++; $display("FAIL reset_retn_high: got %b expected 1", sif.RETN); end
  endtask

  task automatic test_clean_sweep();
    int dj, cl, sb, ma; logic b0;
    fill_clean();
    do_sweep(32'h0, dj, cl, sb, ma, b0);
    n_checks++; if (b0 !== 1'b1) begin n_fail++; $display("FAIL clean_busy_start: got %b expected 1", b0); end
    n_checks++; if (cl != N) begin n_fail++; $display("FAIL clean_cen_cycles: got %0d expected %0d", cl, N); end
    n_checks++; if (sb != 0) begin n_fail++; $display("FAIL clean_addr_seq: got %0d out-of-order expected 0", sb); end
    n_checks++; if (dj != N + 1) begin n_fail++; $display("FAIL clean_done_edge: got %0d expected %0d", dj, N + 1); end
    n_checks++; if (pass !== 1'b1 || err_count !== 13'd0) begin
      n_fail++; $display("FAIL clean_result: got pass=%b err=%0d expected pass=1 err=0", pass, err_count); end
    n_checks++; if (busy !== 1'b0 || sif.CEN !== 1'b1) begin
      n_fail++; $display("FAIL clean_idle_after: got busy=%b cen=%b expected 0/1", busy, sif.CEN); end
  endtask

  task automatic test_wrap();
    int dj, cl, sb, ma; logic b0;
    for (int k = 0; k < N; k++) mem[k] = 32'hFFFF_FFFF + 32'(k);
    do_sweep(32'hFFFF_FFFF, dj, cl, sb, ma, b0);
    n_checks++; if (mem[1] !== 32'h0) begin n_fail++; $display("FAIL wrap_setup: got %0h expected 0", mem[1]); end
    n_checks++; if (pass !== 1'b1 || err_count !== 13'd0) begin
      n_fail++; $display("FAIL wrap_result: got pass=%b err=%0d expected pass=1 err=0", pass, err_count); end
    n_checks++; if (dj != N + 1) begin n_fail++; $display("FAIL wrap_done_edge: got %0d expected %0d", dj, N + 1); end
  endtask

  task automatic test_errors();
    int dj, cl, sb, ma; logic b0;
    fill_clean();
    mem[12'h123] = 32'hDEAD_BEEF;
    mem[12'h800] = 32'h0;
    do_sweep(32'h0, dj, cl, sb, ma, b0);
    n_checks++; if (first_err_addr !== 12'h123) begin n_fail++; $display("FAIL err_first_addr: got %0h expected 123", first_err_addr); end
    n_checks++; if (first_err_data !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL err_first_data: got %0h expected deadbeef", first_err_data); end
    n_checks++; if (pass !== 1'b0) begin n_fail++; $display("FAIL err_pass: got %b expected 0", pass); end
`ifdef SRAM_RD_STOP_ON_FAIL_EN
    n_checks++; if (err_count !== 13'd1) begin n_fail++; $display("FAIL err_count_stop: got %0d expected 1", err_count); end
    n_checks++; if (dj != 32'h126) begin n_fail++; $display("FAIL err_done_stop: got %0h expected 126", dj); end
    n_checks++; if (ma >= 32'h800) begin n_fail++; $display("FAIL err_max_addr_stop: got %0h expected below 800", ma); end
`else
    n_checks++; if (err_count !== 13'd2) begin n_fail++; $display("FAIL err_count: got %0d expected 2", err_count); end
    n_checks++; if (dj != N + 1) begin n_fail++; $display("FAIL err_done_edge: got %0d expected %0d", dj, N + 1); end
    n_checks++; if (cl != N) begin n_fail++; $display("FAIL err_cen_cycles: got %0d expected %0d", cl, N); end
`endif
  endtask

  task automatic test_start_in_done();
    int dj;
    @(negedge top_clk); base = 32'h0; start = 1'b1;
    @(negedge top_clk); start = 1'b0;
    n_checks++; if (done !== 1'b0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL restart_flags: got done=%b busy=%b expected 0/1", done, busy); end
    n_checks++; if (err_count !== 13'd0 || first_err_addr !== 12'h0 || first_err_data !== 32'h0) begin
      n_fail++; $display("FAIL restart_cleared: got %0h/%0h/%0h expected 0/0/0", err_count, first_err_addr, first_err_data); end
    n_checks++; if (sif.CEN !== 1'b0 || sif.A !== 12'h000) begin
      n_fail++; $display("FAIL restart_addr0: got cen=%b a=%0h expected 0/0", sif.CEN, sif.A); end
    dj = -1;
    for (int j = 1; j < N + 20; j++) begin
      @(negedge top_clk);
      if (done) begin dj = j; break; end
    end
    n_checks++; if (dj < 0 || first_err_addr !== 12'h123) begin
      n_fail++; $display("FAIL restart_complete: got done_at=%0d first=%0h expected done and 123", dj, first_err_addr); end
  endtask

  task automatic test_mid_sweep_start();
    int dj;
    fill_clean();
    @(negedge top_clk); base = 32'h0; start = 1'b1;
    @(negedge top_clk); start = 1'b0;
    dj = -1;
    for (int j = 0; j < N + 20; j++) begin
      if (j > 0) @(negedge top_clk);
      if (j == 16) begin
        n_checks++; if (sif.A !== 12'h010) begin n_fail++; $display("FAIL mid_a_before: got %0h expected 10", sif.A); end
        start = 1'b1;
      end
      if (j == 17) begin
        start = 1'b0;
        n_checks++; if (sif.A !== 12'h011 || busy !== 1'b1) begin
          n_fail++; $display("FAIL mid_no_restart: got a=%0h busy=%b expected 11/1", sif.A, busy); end
      end
      if (done) begin dj = j; break; end
    end
    n_checks++; if (dj != N + 1 || pass !== 1'b1) begin
      n_fail++; $display("FAIL mid_done: got done_at=%0d pass=%b expected %0d/1", dj, pass, N + 1); end
  endtask

  task automatic test_reset_mid_sweep();
    int dj, cl, sb, ma; logic b0; logic hit;
    fill_clean();
`ifndef SRAM_RD_STOP_ON_FAIL_EN
    mem[16] = 32'h0BAD_0BAD;
`endif
    @(negedge top_clk); base = 32'h0; start = 1'b1;
    @(negedge top_clk); start = 1'b0;
    hit = 1'b0;
    for (int j = 0; j < N + 20; j++) begin
      if (j > 0) @(negedge top_clk);
      if (sif.A == 12'h400 && !sif.CEN) begin hit = 1'b1; break; end
    end
    n_checks++;
    if (!hit) begin
      n_fail++; $display("FAIL rst_mid_reach: got no A=400 expected A=400 within bound");
    end else begin
`ifndef SRAM_RD_STOP_ON_FAIL_EN
      n_checks++; if (err_count !== 13'd1) begin n_fail++; $display("FAIL rst_mid_pre_err: got %0d expected 1", err_count); end
`endif
      top_reset_n = 1'b0;
      @(negedge top_clk);
      n_checks++; if (sif.CEN !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
        n_fail++; $display("FAIL rst_mid_flags: got cen=%b busy=%b done=%b expected 1/0/0", sif.CEN, busy, done); end
      n_checks++; if (err_count !== 13'd0 || sif.A !== 12'h0) begin
        n_fail++; $display("FAIL rst_mid_clear: got err=%0d a=%0h expected 0/0", err_count, sif.A); end
    end
    top_reset_n = 1'b1;
    fill_clean();
    do_sweep(32'h0, dj, cl, sb, ma, b0);
    n_checks++; if (dj != N + 1 || cl != N || sb != 0) begin
      n_fail++; $display("FAIL rst_after_sweep: got done_at=%0d cen=%0d seq=%0d expected %0d/%0d/0", dj, cl, sb, N + 1, N); end
    n_checks++; if (pass !== 1'b1 || err_count !== 13'd0) begin
      n_fail++; $display("FAIL rst_after_result: got pass=%b err=%0d expected 1/0", pass, err_count); end
  endtask

  initial begin
    test_reset();
    test_clean_sweep();
    test_wrap();
    test_errors();
    test_start_in_done();
    test_mid_sweep_start();
    test_reset_mid_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
